mvau_inp_act_feeder: RTL and testbench

- Producer side of the activation interface into the MVU PE array.
- Accepts one input vector as SF words of TI bits over a valid/ready stream and stores them in a local buffer.
- Replays the stored vector NF times, once per output-neuron fold, to all PEs.
- Generates the sf_clr and nf_clr fold markers that the PE accumulators use to close each dot product.
- Sits between the MVAU input stream and the mvau_stream PE array.

---
 rtl/mvau_inp_act_feeder.sv | 152 +++++++++++++++
 tb/tb_mvau_inp_act_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_inp_act_feeder.sv
// Purpose: buffers one SF-word activation vector and replays it NF times to the MVU PE array with fold markers.
// Latency: 1 cycle from input acceptance to output (pass-through on the first fold), then SF*(NF-1) replayed words.
// Backpressure: out_rdy low with out_v high freezes output, counters and state; in_rdy drops while replaying or stalled.
module mvau_inp_act_feeder #(
  parameter int SIMD    = 2,
  parameter int TSrcI   = 4,
  parameter int TI      = SIMD * TSrcI,
  parameter int MatrixW = 8,
  parameter int MatrixH = 4,
  parameter int PE      = 2,
  parameter int SF      = MatrixW / SIMD,
  parameter int NF      = MatrixH / PE
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          in_v,
  output logic          in_rdy,
  input  logic [TI-1:0] in_act,
  input  logic          out_rdy,
  output logic          out_v,
  output logic [TI-1:0] out_act,
  output logic          sf_clr,
  output logic          nf_clr,
  output logic          do_mvau_stream
);

  // Refuse to build when the matrix does not fold evenly onto the SIMD/PE grid.
  generate
    if ((MatrixW % SIMD) != 0) begin : g_bad_simd
      $error("MatrixW must be a multiple of SIMD");
    end
    if ((MatrixH % PE) != 0) begin : g_bad_pe
      $error("MatrixH must be a multiple of PE");
    end
  endgenerate

  localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);

  // WRITE streams fold 0 straight through while filling the buffer; READ replays folds 1..NF-1.
  typedef enum logic {
    S_WRITE = 1'b0,
    S_READ  = 1'b1
  } state_t;

  state_t          r_state;
  logic [SF_W-1:0] r_sf_cnt;
  logic [NF_W-1:0] r_nf_cnt;
  logic            r_out_v;
  logic [TI-1:0]   r_out_act;
  logic            r_sf_clr;
  logic            r_nf_clr;
  logic            r_busy;
  logic [TI-1:0]   r_buf [SF];

  logic w_adv;
  logic w_acc;
  logic w_sf_last;
  logic w_nf_last;
  logic w_nf_xfer;

  // The output register may load whenever it is empty or its word is being taken this cycle.
  assign w_adv     = ~r_out_v | out_rdy;
  assign in_rdy    = (r_state == S_WRITE) && w_adv;
  assign w_acc     = in_v & in_rdy;
  assign w_sf_last = (r_sf_cnt == SF_LAST);
  assign w_nf_last = (r_nf_cnt == NF_LAST);
  assign w_nf_xfer = r_out_v & out_rdy & r_nf_clr;

  assign out_v   = r_out_v;
  assign out_act = r_out_act;
  assign sf_clr  = r_sf_clr;
  assign nf_clr  = r_nf_clr;
  // With a single fold the vector is never held internally, so activity is just the output valid.
  assign do_mvau_stream = (NF == 1) ? r_out_v : (r_out_v | r_busy);

  // Vector buffer: filled during fold 0, contents deliberately left unreset.
  always_ff @(posedge aclk) begin
    if (w_acc) begin
      r_buf[r_sf_cnt] <= in_act;
    end
  end

  // Fold sequencer with registered output word and fold markers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= S_WRITE;
      r_sf_cnt  <= '0;
      r_nf_cnt  <= '0;
      r_out_v   <= 1'b0;
      r_out_act <= '0;
      r_sf_clr  <= 1'b0;
      r_nf_clr  <= 1'b0;
    end else if (w_adv) begin
      case (r_state)
        S_WRITE: begin
          if (w_acc) begin
            r_out_act <= in_act;
            r_out_v   <= 1'b1;
            r_sf_clr  <= w_sf_last;
            r_nf_clr  <= w_sf_last && (NF == 1);
            if (w_sf_last) begin
              r_sf_cnt <= '0;
              if (NF > 1) begin
                r_nf_cnt <= NF_W'(1);
                r_state  <= S_READ;
              end
            end else begin
              r_sf_cnt <= r_sf_cnt + SF_W'(1);
            end
          end else begin
            r_out_v  <= 1'b0;
            r_sf_clr <= 1'b0;
            r_nf_clr <= 1'b0;
          end
        end
        S_READ: begin
          r_out_act <= r_buf[r_sf_cnt];
          r_out_v   <= 1'b1;
          r_sf_clr  <= w_sf_last;
          r_nf_clr  <= w_sf_last && w_nf_last;
          if (w_sf_last) begin
            r_sf_cnt <= '0;
            if (w_nf_last) begin
              r_nf_cnt <= '0;
              r_state  <= S_WRITE;
            end else begin
              r_nf_cnt <= r_nf_cnt + NF_W'(1);
            end
          end else begin
            r_sf_cnt <= r_sf_cnt + SF_W'(1);
          end
        end
        default: r_state <= S_WRITE;
      endcase
    end
  end

  // Vector-in-flight flag: a new vector's first word wins over the previous vector's final transfer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_busy <= 1'b0;
    end else if (w_acc && (r_sf_cnt == '0)) begin
      r_busy <= 1'b1;
    end else if (w_nf_xfer) begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mvau_inp_act_feeder.sv
// Purpose: directed self-checking bench for mvau_inp_act_feeder (default NF=2 instance and an NF=1 instance).
// Latency: each step drives inputs on the falling edge and samples outputs 1 time unit later.
// Backpressure: out_rdy is driven per step from the stimulus tables.
module tb_mvau_inp_act_feeder;

  logic       aclk = 1'b0;
  logic       areset;

  logic       in_v0, out_rdy0, in_rdy0, out_v0, sf_clr0, nf_clr0, do0;
  logic [7:0] in_act0, out_act0;
  logic       in_v1, out_rdy1, in_rdy1, out_v1, sf_clr1, nf_clr1, do1;
  logic [7:0] in_act1, out_act1;

  int n_cmp  = 0;
  int n_fail = 0;

  // One step: inputs {iv, ordy, ia}; expected flags {v,sf,nf,rdy,do} and word (00 when out_v is 0).
  typedef struct packed {
    logic       iv;
    logic       ordy;
    logic [7:0] ia;
    logic [4:0] ef;
    logic [7:0] ea;
  } step_t;

  logic [12:0] obs;

  always #5 aclk = ~aclk;

  mvau_inp_act_feeder dut0 (
    .aclk(aclk), .areset(areset),
    .in_v(in_v0), .in_rdy(in_rdy0), .in_act(in_act0),
    .out_rdy(out_rdy0), .out_v(out_v0), .out_act(out_act0),
    .sf_clr(sf_clr0), .nf_clr(nf_clr0), .do_mvau_stream(do0)
  );

  mvau_inp_act_feeder #(.MatrixH(2), .PE(2)) dut1 (
    .aclk(aclk), .areset(areset),
    .in_v(in_v1), .in_rdy(in_rdy1), .in_act(in_act1),
    .out_rdy(out_rdy1), .out_v(out_v1), .out_act(out_act1),
    .sf_clr(sf_clr1), .nf_clr(nf_clr1), .do_mvau_stream(do1)
  );

  function automatic step_t mk(input logic [1:0] ctl, input logic [7:0] ia,
                               input logic [7:0] ea, input logic [4:0] ef);
    step_t s;
    s.iv   = ctl[1];
    s.ordy = ctl[0];
    s.ia   = ia;
    s.ef   = ef;
    s.ea   = ea;
    return s;
  endfunction

  task automatic drive0(input step_t s);
    @(negedge aclk);
    in_v0 = s.iv; in_act0 = s.ia; out_rdy0 = s.ordy;
    #1;
    obs = {out_v0, sf_clr0, nf_clr0, in_rdy0, do0, (out_v0 ? out_act0 : 8'h00)};
  endtask

  task automatic drive1(input step_t s);
    @(negedge aclk);
    in_v1 = s.iv; in_act1 = s.ia; out_rdy1 = s.ordy;
    #1;
    obs = {out_v1, sf_clr1, nf_clr1, in_rdy1, do1, (out_v1 ? out_act1 : 8'h00)};
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_v0, sf_clr0, nf_clr0, do0} !== 4'b0000 || out_act0 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs_dut0: got v/sf/nf/do=%b act=%h, expected 0000 act=00",
               {out_v0, sf_clr0, nf_clr0, do0}, out_act0);
    end
    n_cmp++;
    if (in_rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_rdy_dut0: got %b, expected 1", in_rdy0);
    end
    n_cmp++;
    if ({out_v1, sf_clr1, nf_clr1, do1, in_rdy1} !== 5'b00001 || out_act1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dut1: got v/sf/nf/do/rdy=%b act=%h, expected 00001 act=00",
               {out_v1, sf_clr1, nf_clr1, do1, in_rdy1}, out_act1);
    end
  endtask

  task automatic test_basic();
    step_t s [10];
    s = '{mk(2'b11,8'h11,8'h00,5'b00010), mk(2'b11,8'h22,8'h11,5'b10011),
          mk(2'b11,8'h33,8'h22,5'b10011), mk(2'b11,8'h44,8'h33,5'b10011),
          mk(2'b01,8'h00,8'h44,5'b11001), mk(2'b01,8'h00,8'h11,5'b10001),
          mk(2'b01,8'h00,8'h22,5'b10001), mk(2'b01,8'h00,8'h33,5'b10001),
          mk(2'b01,8'h00,8'h44,5'b11111), mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (s[i]) begin
      drive0(s[i]);
      n_cmp++;
      if (obs !== {s[i].ef, s[i].ea}) begin
        n_fail++;
        $display("FAIL basic step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], s[i].ef, s[i].ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s [18];
    s = '{mk(2'b11,8'h11,8'h00,5'b00010), mk(2'b11,8'h22,8'h11,5'b10011),
          mk(2'b11,8'h33,8'h22,5'b10011), mk(2'b11,8'h44,8'h33,5'b10011),
          mk(2'b11,8'hA1,8'h44,5'b11001), mk(2'b11,8'hA1,8'h11,5'b10001),
          mk(2'b11,8'hA1,8'h22,5'b10001), mk(2'b11,8'hA1,8'h33,5'b10001),
          mk(2'b11,8'hA1,8'h44,5'b11111), mk(2'b11,8'hA2,8'hA1,5'b10011),
          mk(2'b11,8'hA3,8'hA2,5'b10011), mk(2'b11,8'hA4,8'hA3,5'b10011),
          mk(2'b01,8'h00,8'hA4,5'b11001), mk(2'b01,8'h00,8'hA1,5'b10001),
          mk(2'b01,8'h00,8'hA2,5'b10001), mk(2'b01,8'h00,8'hA3,5'b10001),
          mk(2'b01,8'h00,8'hA4,5'b11111), mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (s[i]) begin
      drive0(s[i]);
      n_cmp++;
      if (obs !== {s[i].ef, s[i].ea}) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], s[i].ef, s[i].ea);
      end
    end
  endtask

  task automatic test_backpressure();
    step_t s [15];
    s = '{mk(2'b11,8'h11,8'h00,5'b00010), mk(2'b11,8'h22,8'h11,5'b10011),
          mk(2'b11,8'h33,8'h22,5'b10011), mk(2'b10,8'h44,8'h33,5'b10001),
          mk(2'b11,8'h44,8'h33,5'b10011), mk(2'b01,8'h00,8'h44,5'b11001),
          mk(2'b01,8'h00,8'h11,5'b10001), mk(2'b00,8'h00,8'h22,5'b10001),
          mk(2'b00,8'h00,8'h22,5'b10001), mk(2'b00,8'h00,8'h22,5'b10001),
          mk(2'b01,8'h00,8'h22,5'b10001), mk(2'b01,8'h00,8'h33,5'b10001),
          mk(2'b00,8'h00,8'h44,5'b11101), mk(2'b01,8'h00,8'h44,5'b11111),
          mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (s[i]) begin
      drive0(s[i]);
      n_cmp++;
      if (obs !== {s[i].ef, s[i].ea}) begin
        n_fail++;
        $display("FAIL backpressure step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], s[i].ef, s[i].ea);
      end
    end
  endtask

  task automatic test_nf1();
    step_t s [7];
    s = '{mk(2'b11,8'h01,8'h00,5'b00010), mk(2'b11,8'h02,8'h01,5'b10011),
          mk(2'b11,8'h03,8'h02,5'b10011), mk(2'b11,8'h04,8'h03,5'b10011),
          mk(2'b11,8'h05,8'h04,5'b11111), mk(2'b01,8'h00,8'h05,5'b10011),
          mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (s[i]) begin
      drive1(s[i]);
      n_cmp++;
      if (obs !== {s[i].ef, s[i].ea}) begin
        n_fail++;
        $display("FAIL nf1 step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], s[i].ef, s[i].ea);
      end
    end
    in_v1 = 1'b0;
  endtask

  task automatic test_async_reset();
    step_t pre [8];
    step_t post [10];
    pre = '{mk(2'b11,8'h11,8'h00,5'b00010), mk(2'b11,8'h22,8'h11,5'b10011),
            mk(2'b11,8'h33,8'h22,5'b10011), mk(2'b11,8'h44,8'h33,5'b10011),
            mk(2'b01,8'h00,8'h44,5'b11001), mk(2'b01,8'h00,8'h11,5'b10001),
            mk(2'b01,8'h00,8'h22,5'b10001), mk(2'b01,8'h00,8'h33,5'b10001)};
    post = '{mk(2'b11,8'h55,8'h00,5'b00010), mk(2'b11,8'h66,8'h55,5'b10011),
             mk(2'b11,8'h77,8'h66,5'b10011), mk(2'b11,8'h88,8'h77,5'b10011),
             mk(2'b01,8'h00,8'h88,5'b11001), mk(2'b01,8'h00,8'h55,5'b10001),
             mk(2'b01,8'h00,8'h66,5'b10001), mk(2'b01,8'h00,8'h77,5'b10001),
             mk(2'b01,8'h00,8'h88,5'b11111), mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (pre[i]) begin
      drive0(pre[i]);
      n_cmp++;
      if (obs !== {pre[i].ef, pre[i].ea}) begin
        n_fail++;
        $display("FAIL async_reset_pre step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], pre[i].ef, pre[i].ea);
      end
    end
    areset = 1'b1;
    #1;
    n_cmp++;
    if ({out_v0, sf_clr0, nf_clr0, do0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_flags: got v/sf/nf/do=%b, expected 0000",
               {out_v0, sf_clr0, nf_clr0, do0});
    end
    n_cmp++;
    if (out_act0 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_act: got %h, expected 00", out_act0);
    end
    @(negedge aclk);
    areset = 1'b0;
    foreach (post[i]) begin
      drive0(post[i]);
      n_cmp++;
      if (obs !== {post[i].ef, post[i].ea}) begin
        n_fail++;
        $display("FAIL async_reset_post step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], post[i].ef, post[i].ea);
      end
    end
  endtask

  task automatic test_input_gaps();
    step_t s [13];
    s = '{mk(2'b11,8'h11,8'h00,5'b00010), mk(2'b01,8'h00,8'h11,5'b10011),
          mk(2'b11,8'h22,8'h00,5'b00011), mk(2'b01,8'h00,8'h22,5'b10011),
          mk(2'b11,8'h33,8'h00,5'b00011), mk(2'b01,8'h00,8'h33,5'b10011),
          mk(2'b11,8'h44,8'h00,5'b00011), mk(2'b01,8'h00,8'h44,5'b11001),
          mk(2'b01,8'h00,8'h11,5'b10001), mk(2'b01,8'h00,8'h22,5'b10001),
          mk(2'b01,8'h00,8'h33,5'b10001), mk(2'b01,8'h00,8'h44,5'b11111),
          mk(2'b01,8'h00,8'h00,5'b00010)};
    foreach (s[i]) begin
      drive0(s[i]);
      n_cmp++;
      if (obs !== {s[i].ef, s[i].ea}) begin
        n_fail++;
        $display("FAIL input_gaps step %0d: got v/sf/nf/rdy/do=%b act=%h, expected %b act=%h",
                 i, obs[12:8], obs[7:0], s[i].ef, s[i].ea);
      end
    end
  endtask

  initial begin
    areset   = 1'b1;
    in_v0    = 1'b0; in_act0 = 8'h00; out_rdy0 = 1'b1;
    in_v1    = 1'b0; in_act1 = 8'h00; out_rdy1 = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_nf1();
    test_async_reset();
    test_input_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
